stopwatch_lap: RTL
==================

STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, in_clk cycles per one-second tick at nominal speed (min 4).
REQ-002 SHALL have parameter MAX_MIN, default 99, highest minute value (1..99).
REQ-003 SHALL have parameter LAP_DEPTH, default 4, lap buffer entries (power of 2, min 2).
REQ-004 SHALL have the following ports:
- in_clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; 1 = count, 0 = paused.
- up  input  1  direction request; 1 = count up, 0 = count down.
- plus_min2  input  1  one-cycle pulse; add 2 minutes.
- speedup  input  1  level; halve the tick period.
- slowdown  input  1  level; double the tick period.
- lap  input  1  one-cycle pulse; capture the current time.
- lap_ready  input  1  consumer accepts the lap head.
- lap_valid  output  1  lap buffer is not empty.
- lap_data  output  16  head entry, {MM1,MM0,SS1,SS0}.
- lap_count  output  $clog2(LAP_DEPTH+1)  number of buffered entries.
- lap_overflow  output  1  sticky; a lap was dropped because the buffer was full.
- err  output  1  sticky; count limit reached (error code 1).
- SS0, SS1, MM0, MM1  output  4 each  BCD seconds units, seconds tens, minutes units, minutes tens.

Function
REQ-005 Prescaler SHALL increment while start=1 && err=0, hold its value while paused, and emit a tick when it reaches terminal count T-1, wrapping to 0.
REQ-006 Time registers SHALL update on the in_clk edge at which the prescaler is at T-1 (one-cycle latency from terminal count).
REQ-007 Direction register SHALL sample up only while start=0; changes to up while running SHALL be ignored.
REQ-008 Up-count:
- SS0 9->0 carries into SS1.
- SS1 5->0 carries into the minutes.
- Minutes roll over at 9 in BCD.
REQ-009 Down-count SHALL be the mirror of REQ-008: SS0 0->9 borrows, SS1 0->5 borrows.
REQ-010 A tick at MAX_MIN:59 counting up, or at 00:00 counting down, SHALL hold the time, set err, and stop the prescaler.
REQ-011 err SHALL be cleared only by reset.
REQ-012 plus_min2 with start=0 SHALL add 2 to the minutes in the next cycle, saturating at MAX_MIN with seconds unchanged; it SHALL be ignored while start=1.
REQ-013 lap with start=1 SHALL push the time value present in that cycle (before any same-cycle tick update).
REQ-014 A lap with start=0 SHALL be ignored.
REQ-015 A push with the buffer full and no pop SHALL drop the entry and set lap_overflow; lap_overflow SHALL be cleared only by reset.
REQ-016 Pop SHALL occur when lap_valid && lap_ready; lap_data SHALL present the oldest entry.
REQ-017 Push and pop in the same cycle when full SHALL both be accepted, with no overflow.
REQ-018 A push to an empty buffer SHALL have no bypass; lap_valid rises the next cycle.

Reset
REQ-019 While reset=1 at the in_clk edge, the block SHALL clear:
- SS0..MM1 to 0.
- the prescaler.
- err and lap_overflow.
- the buffer (lap_valid=0, lap_count=0).
REQ-020 Reset SHALL set direction to up.
REQ-021 Reset SHALL take priority over every other input, including mid-count and a simultaneous lap or pop.

Configuration
REQ-022 With STOPWATCH_SPEED_CTRL_EN defined, T SHALL be:
- TICK_DIV/2 when only speedup=1.
- 2*TICK_DIV when only slowdown=1.
- TICK_DIV otherwise.
REQ-023 With STOPWATCH_SPEED_CTRL_EN defined, if a speed change leaves the prescaler >= T-1, the next edge SHALL produce a tick and wrap.
REQ-024 Without STOPWATCH_SPEED_CTRL_EN, speedup and slowdown SHALL remain ports but be ignored, with T=TICK_DIV.

Structure
REQ-025 Package stopwatch_pkg SHALL hold:
- bcd_time_t (four 4-bit fields).
- TIME_W=16.
- DIGIT_MAX=9.
- SEC_TENS_MAX=5.
REQ-026 The lap buffer SHALL be the sub-module lap_fifo, parametrised by depth and width.

Verification (TICK_DIV=4, LAP_DEPTH=4, MAX_MIN=99)
REQ-027 Preload 00:59, start=1, up=1, run one tick -> MM0=1, SS1=0, SS0=0, 4 cycles after start.
REQ-028 Start at 00:01 with up=0 and run two ticks -> 00:00 after the first tick; the second tick holds 00:00 and sets err=1; further cycles show no change.
REQ-029 start=0, up=1, plus_min2 at 98:30 -> 99:30; a second pulse -> 99:30 unchanged.
REQ-030 Five laps while running with lap_ready=0 -> lap_count=4 and lap_overflow=1.
REQ-031 Continuing from REQ-030, a lap with lap_ready=1 while full -> lap_count stays 4, the oldest entry leaves, and the new entry is at the tail.
REQ-032 Reset asserted mid-count with lap=1 in the same cycle -> all outputs 0, lap_valid=0.
REQ-033 With the macro, speedup=1 -> tick every 2 cycles.
REQ-034 With the macro, speedup=1 and slowdown=1 -> tick every 4 cycles.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types, constants and BCD helper functions for the
//               stopwatch_lap block.
//               Contents: bcd_time_t, TIME_W, DIGIT_MAX, SEC_TENS_MAX,
//               bcd2_to_bin(), bin_to_bcd2().
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int         TIME_W       = 16;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Field order matches the lap_data layout {MM1,MM0,SS1,SS0}.
    typedef struct packed {
        logic [3:0] mm1;
        logic [3:0] mm0;
        logic [3:0] ss1;
        logic [3:0] ss0;
    } bcd_time_t;

    // Two BCD digits (0..99) to binary.
    function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens,
                                               input logic [3:0] units);
        return (7'(tens) * 7'd10) + 7'(units);
    endfunction

    // Binary (0..99) to two BCD digits {tens, units}.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] value);
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lap_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lap_fifo
// Description : Synchronous FIFO for lap captures. No write-through bypass:
//               an entry pushed into an empty buffer becomes visible on the
//               following cycle. A push while full is accepted only when a
//               pop happens in the same cycle; otherwise it is dropped and
//               the sticky overflow flag is set.
//   Ports     : clk, rst (sync, active-high)
//               i_push, i_data   - write request and data
//               i_ready          - consumer accepts head (pop when valid)
//               o_valid, o_data  - buffer not empty, oldest entry
//               o_count          - number of stored entries
//               o_overflow       - sticky drop indicator
// Revision    : 1.0 - initial release
// ============================================================================
module lap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == c_CW'(DEPTH));
    assign w_pop  = i_ready && (r_count != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign w_push = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (i_push && !w_push)     r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: contents are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid    = (r_count != '0);
    assign o_data     = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/stopwatch_lap.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_lap
// Description : BCD MM:SS stopwatch with up/down counting, +2 minute preset,
//               sticky limit error and a lap capture FIFO.
//   Ports     : in_clk, reset (sync, active-high)
//               start      - run (1) / pause (0)
//               up         - direction, sampled only while paused
//               plus_min2  - pulse, +2 minutes while paused (saturating)
//               speedup, slowdown - tick period control (optional feature)
//               lap, lap_ready    - capture pulse / consumer handshake
//               lap_valid, lap_data, lap_count, lap_overflow - lap buffer
//               err        - sticky count-limit flag
//               SS0, SS1, MM0, MM1 - BCD time digits
//   Config    : define STOPWATCH_SPEED_CTRL_EN to enable speedup/slowdown;
//               otherwise both inputs are ignored and T = TICK_DIV.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int MAX_MIN   = 99,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           in_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           up,
    input  logic                           plus_min2,
    input  logic                           speedup,
    input  logic                           slowdown,
    input  logic                           lap,
    input  logic                           lap_ready,
    output logic                           lap_valid,
    output logic [TIME_W-1:0]              lap_data,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_overflow,
    output logic                           err,
    output logic [3:0]                     SS0,
    output logic [3:0]                     SS1,
    output logic [3:0]                     MM0,
    output logic [3:0]                     MM1
);

    // Wide enough for the slowest period (2*TICK_DIV).
    localparam int         c_PRESC_W  = $clog2(2*TICK_DIV);
    localparam logic [3:0] c_MAX_MM1  = 4'(MAX_MIN / 10);
    localparam logic [3:0] c_MAX_MM0  = 4'(MAX_MIN % 10);
    localparam logic [7:0] c_MAX_MIN8 = 8'(MAX_MIN);

    bcd_time_t            r_time;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_err;
    logic                 r_dir;

    bcd_time_t            w_time_d;
    logic                 w_err_d;
    logic [c_PRESC_W-1:0] w_term;
    logic                 w_run;
    logic                 w_tick;
    logic                 w_at_max;
    logic                 w_at_zero;
    logic [7:0]           w_min_sum;
    logic                 w_lap_push;

    // ---------------------------------------------------------------------
    // Terminal count (T-1)
    // ---------------------------------------------------------------------
`ifdef STOPWATCH_SPEED_CTRL_EN
    always_comb begin
        if (speedup && !slowdown)
            w_term = c_PRESC_W'(TICK_DIV/2 - 1);
        else if (slowdown && !speedup)
            w_term = c_PRESC_W'(2*TICK_DIV - 1);
        else
            w_term = c_PRESC_W'(TICK_DIV - 1);
    end
`else
    logic w_unused_speed;
    assign w_unused_speed = speedup ^ slowdown;
    assign w_term         = c_PRESC_W'(TICK_DIV - 1);
`endif

    // ---------------------------------------------------------------------
    // Prescaler: ">=" so a shortened period that leaves the count past the
    // new terminal value still ticks and wraps on the next edge.
    // ---------------------------------------------------------------------
    assign w_run  = start && !r_err;
    assign w_tick = w_run && (r_presc >= w_term);

    always_ff @(posedge in_clk) begin
        if (reset)       r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else if (w_run)  r_presc <= r_presc + 1'b1;
    end

    // ---------------------------------------------------------------------
    // Time next-state
    // ---------------------------------------------------------------------
    assign w_at_max  = (r_time.mm1 == c_MAX_MM1) && (r_time.mm0 == c_MAX_MM0) &&
                       (r_time.ss1 == SEC_TENS_MAX) && (r_time.ss0 == DIGIT_MAX);
    assign w_at_zero = (r_time == '0);

    always_comb begin
        w_time_d  = r_time;
        w_err_d   = r_err;
        w_min_sum = '0;
        if (w_tick) begin
            if (r_dir) begin
                if (w_at_max) begin
                    w_err_d = 1'b1;
                end else if (r_time.ss0 != DIGIT_MAX) begin
                    w_time_d.ss0 = r_time.ss0 + 4'd1;
                end else begin
                    w_time_d.ss0 = 4'd0;
                    if (r_time.ss1 != SEC_TENS_MAX) begin
                        w_time_d.ss1 = r_time.ss1 + 4'd1;
                    end else begin
                        w_time_d.ss1 = 4'd0;
                        if (r_time.mm0 != DIGIT_MAX) begin
                            w_time_d.mm0 = r_time.mm0 + 4'd1;
                        end else begin
                            w_time_d.mm0 = 4'd0;
                            w_time_d.mm1 = r_time.mm1 + 4'd1;
                        end
                    end
                end
            end else begin
                if (w_at_zero) begin
                    w_err_d = 1'b1;
                end else if (r_time.ss0 != 4'd0) begin
                    w_time_d.ss0 = r_time.ss0 - 4'd1;
                end else begin
                    w_time_d.ss0 = DIGIT_MAX;
                    if (r_time.ss1 != 4'd0) begin
                        w_time_d.ss1 = r_time.ss1 - 4'd1;
                    end else begin
                        w_time_d.ss1 = SEC_TENS_MAX;
                        if (r_time.mm0 != 4'd0) begin
                            w_time_d.mm0 = r_time.mm0 - 4'd1;
                        end else begin
                            w_time_d.mm0 = DIGIT_MAX;
                            w_time_d.mm1 = r_time.mm1 - 4'd1;
                        end
                    end
                end
            end
        end else if (plus_min2 && !start) begin
            // Ticks need start=1, so this branch never races a tick.
            w_min_sum = {1'b0, bcd2_to_bin(r_time.mm1, r_time.mm0)} + 8'd2;
            if (w_min_sum > c_MAX_MIN8) w_min_sum = c_MAX_MIN8;
            {w_time_d.mm1, w_time_d.mm0} = bin_to_bcd2(w_min_sum[6:0]);
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            r_time <= '0;
            r_err  <= 1'b0;
            r_dir  <= 1'b1;
        end else begin
            r_time <= w_time_d;
            r_err  <= w_err_d;
            // Direction is frozen while running.
            if (!start) r_dir <= up;
        end
    end

    // ---------------------------------------------------------------------
    // Lap buffer: captures the time held before any same-cycle tick update
    // ---------------------------------------------------------------------
    assign w_lap_push = lap && start;

    lap_fifo #(
        .DEPTH (LAP_DEPTH),
        .WIDTH (TIME_W)
    ) u_lap_fifo (
        .clk        (in_clk),
        .rst        (reset),
        .i_push     (w_lap_push),
        .i_data     (r_time),
        .i_ready    (lap_ready),
        .o_valid    (lap_valid),
        .o_data     (lap_data),
        .o_count    (lap_count),
        .o_overflow (lap_overflow)
    );

    assign err = r_err;
    assign SS0 = r_time.ss0;
    assign SS1 = r_time.ss1;
    assign MM0 = r_time.mm0;
    assign MM1 = r_time.mm1;

endmodule
`default_nettype wire
